// File: rtl/tx_frame_arbiter.sv
// Round-robin sharing of one UART TX frame channel among N_REQ engines with one-deep slots.
// Define TX_ARB_DROP_CNT_EN to add drop_cnt, a saturating count of dropped requests.
`timescale 1ns/1ps
module tx_frame_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter logic [7:0]  ADDR_BASE   = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_buysell,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_addr,
    output logic [7:0]         tx_buysell,
    output logic [31:0]        tx_timestamp,
    output logic               tx_dv,
    input  logic               tx_busy,
    output logic               err_timeout
`ifdef TX_ARB_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e             state_q, state_d;
    logic [31:0]        ts_cnt_q;
    logic [N_REQ-1:0]   pend_q, pend_d, accept, grant_vec;
    logic [7:0]         slot_bs_q [N_REQ];
    logic [31:0]        slot_ts_q [N_REQ];
    logic [IDX_W-1:0]   rr_q, rr_d, win_idx;
    logic               win_found, grant;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         tx_addr_q, tx_addr_d, tx_bs_q, tx_bs_d;
    logic [31:0]        tx_ts_q, tx_ts_d;
    logic               tx_dv_q, tx_dv_d, err_q, err_d;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        if (v >= N_REQ) return IDX_W'(v - N_REQ);
        return IDX_W'(v);
    endfunction

    // First pending slot at or after the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!win_found && pend_q[wrap_idx(32'(rr_q) + k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(32'(rr_q) + k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        timer_d   = timer_q;
        tx_addr_d = tx_addr_q;
        tx_bs_d   = tx_bs_q;
        tx_ts_d   = tx_ts_q;
        tx_dv_d   = tx_dv_q;
        err_d     = 1'b0;
        grant     = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found && !tx_busy) begin
                    grant     = 1'b1;
                    tx_addr_d = ADDR_BASE + 8'(win_idx);
                    tx_bs_d   = slot_bs_q[win_idx];
                    tx_ts_d   = slot_ts_q[win_idx];
                    tx_dv_d   = 1'b1;
                    timer_d   = '0;
                    rr_d      = wrap_idx(32'(win_idx) + 1);
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (tx_busy) begin
                    tx_dv_d = 1'b0;
                    state_d = StWait;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    tx_dv_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWait: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The granted slot is freed in the same cycle; no request can land on it then.
    always_comb begin
        accept    = req_valid & ~pend_q;
        grant_vec = grant ? (N_REQ'(1) << win_idx) : '0;
        pend_d    = (pend_q & ~grant_vec) | accept;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ts_cnt_q  <= '0;
            pend_q    <= '0;
            rr_q      <= '0;
            timer_q   <= '0;
            tx_addr_q <= '0;
            tx_bs_q   <= '0;
            tx_ts_q   <= '0;
            tx_dv_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_cnt_q  <= ts_cnt_q + 32'd1;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            timer_q   <= timer_d;
            tx_addr_q <= tx_addr_d;
            tx_bs_q   <= tx_bs_d;
            tx_ts_q   <= tx_ts_d;
            tx_dv_q   <= tx_dv_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                slot_bs_q[i] <= '0;
                slot_ts_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) begin
                    slot_bs_q[i] <= req_buysell[8*i +: 8];
                    slot_ts_q[i] <= ts_cnt_q;
                end
            end
        end
    end

`ifdef TX_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(req_valid & pend_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign req_ready    = ~pend_q;
    assign tx_addr      = tx_addr_q;
    assign tx_buysell   = tx_bs_q;
    assign tx_timestamp = tx_ts_q;
    assign tx_dv        = tx_dv_q;
    assign err_timeout  = err_q;

endmodule
